// File: rtl/pipeline_controller_pkg.sv
// +--------------------------------------------------------------------------+
// | pipeline_controller_pkg : shared stall/sequencer definitions  (rev 1.0)  |
// +--------------------------------------------------------------------------+
`default_nettype none

package pipeline_controller_pkg;

  localparam int STALL_WIDTH  = 6;
  localparam int STALL_PC     = 0;
  localparam int STALL_IF_ID  = 1;
  localparam int STALL_ID_EX  = 2;
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;
  localparam int STALL_WB     = 5;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'b00,
    SEQ_BUSY = 2'b01,
    SEQ_DONE = 2'b10
  } seq_state_t;

  localparam logic RESET_ENABLE  = 1'b0;
  localparam logic WRITE_DISABLE = 1'b0;

  // Operator/category loaded into ID/EX when a bubble is inserted.
  localparam logic [3:0] NOP_OPERATOR = 4'd0;
  localparam logic [2:0] NOP_CATEGORY = 3'd0;

  // Hold every stage from the PC up to and including 'last'.
  function automatic logic [STALL_WIDTH-1:0] stall_through(input int last);
    logic [STALL_WIDTH-1:0] v;
    v = '0;
    for (int b = 0; b < STALL_WIDTH; b++) begin
      if (b <= last) v[b] = 1'b1;
    end
    return v;
  endfunction

  localparam logic [STALL_WIDTH-1:0] STALL_NONE     = '0;
  localparam logic [STALL_WIDTH-1:0] STALL_EX_HOLD  = stall_through(STALL_EX_MEM);
  localparam logic [STALL_WIDTH-1:0] STALL_LOAD_USE = stall_through(STALL_ID_EX);

endpackage

`default_nettype wire

// File: rtl/pipeline_controller_if.sv
// +--------------------------------------------------------------------------+
// | pipeline_controller_if : hazard requests in, stall/flush controls out    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface pipeline_controller_if;
  import pipeline_controller_pkg::*;

  logic                   id_stall_request;
  logic                   ex_multi_cycle_start;
  logic                   ex_multi_cycle_cancel;
  logic                   flush;
  logic [STALL_WIDTH-1:0] stall;
  logic                   flush_out;
  logic                   id_ex_bubble;
  logic                   ex_multi_cycle_busy;
  logic                   ex_multi_cycle_done;

  // Pipeline side: raises hazards, consumes controls.
  modport master (
    output id_stall_request, ex_multi_cycle_start, ex_multi_cycle_cancel, flush,
    input  stall, flush_out, id_ex_bubble, ex_multi_cycle_busy, ex_multi_cycle_done
  );

  modport slave (
    input  id_stall_request, ex_multi_cycle_start, ex_multi_cycle_cancel, flush,
    output stall, flush_out, id_ex_bubble, ex_multi_cycle_busy, ex_multi_cycle_done
  );

endinterface

`default_nettype wire

// File: rtl/pipeline_controller_sequencer.sv
// +--------------------------------------------------------------------------+
// | multi_cycle_sequencer : IDLE/BUSY/DONE hold sequencer for EX ops (r1.0)  |
// +--------------------------------------------------------------------------+
`default_nettype none

module multi_cycle_sequencer
  import pipeline_controller_pkg::*;
#(
  parameter int MULTI_CYCLE_LATENCY = 32,
  parameter int COUNTER_WIDTH       = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic cancel,
  input  logic flush,
  output logic busy,
  output logic done,
  output logic ex_stall
);

  localparam logic [COUNTER_WIDTH-1:0] COUNT_LOAD = COUNTER_WIDTH'(MULTI_CYCLE_LATENCY - 1);

  if (MULTI_CYCLE_LATENCY < 1) begin : g_latency_check
    $error("MULTI_CYCLE_LATENCY must be at least 1");
  end
  if ((64'd1 << COUNTER_WIDTH) <= 64'(MULTI_CYCLE_LATENCY)) begin : g_width_check
    $error("COUNTER_WIDTH too small for MULTI_CYCLE_LATENCY");
  end

  seq_state_t               state, state_next;
  logic [COUNTER_WIDTH-1:0] count, count_next;

  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      state <= SEQ_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    busy       = 1'b0;
    done       = 1'b0;
    ex_stall   = 1'b0;
    case (state)
      SEQ_IDLE: begin
        // Stall already in the accepting cycle so ID/EX is frozen from t on.
        if (start && !flush) begin
          state_next = SEQ_BUSY;
          count_next = COUNT_LOAD;
          ex_stall   = 1'b1;
        end
      end
      SEQ_BUSY: begin
        busy     = 1'b1;
        ex_stall = 1'b1;
        if (flush || cancel) begin
          state_next = SEQ_IDLE;
          count_next = '0;
        end else if (count == '0) begin
          state_next = SEQ_DONE;
        end else begin
          count_next = count - 1'b1;
        end
      end
      SEQ_DONE: begin
        done       = 1'b1;
        state_next = SEQ_IDLE;
      end
      default: begin
        state_next = SEQ_IDLE;
        count_next = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_controller.sv
// +--------------------------------------------------------------------------+
// | pipeline_controller : stall/flush priority mux for the 5-stage pipe r1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int MULTI_CYCLE_LATENCY = 32,
  parameter int COUNTER_WIDTH       = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  pipeline_controller_if.slave  ctl
);

  logic ex_stall;

  multi_cycle_sequencer #(
    .MULTI_CYCLE_LATENCY (MULTI_CYCLE_LATENCY),
    .COUNTER_WIDTH       (COUNTER_WIDTH)
  ) u_sequencer (
    .clock    (clock),
    .reset    (reset),
    .start    (ctl.ex_multi_cycle_start),
    .cancel   (ctl.ex_multi_cycle_cancel),
    .flush    (ctl.flush),
    .busy     (ctl.ex_multi_cycle_busy),
    .done     (ctl.ex_multi_cycle_done),
    .ex_stall (ex_stall)
  );

  // Flush beats an EX hold, which in turn masks a load-use request.
  always_comb begin
    ctl.stall        = STALL_NONE;
    ctl.flush_out    = 1'b0;
    ctl.id_ex_bubble = 1'b0;
    if (ctl.flush) begin
      ctl.flush_out = 1'b1;
    end else if (ex_stall) begin
      ctl.stall = STALL_EX_HOLD;
    end else if (ctl.id_stall_request) begin
      ctl.stall        = STALL_LOAD_USE;
      ctl.id_ex_bubble = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_controller.sv
// +--------------------------------------------------------------------------+
// | tb_pipeline_controller : directed-vector bench, LATENCY=4 (rev 1.0)      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_controller;

  logic clock;
  logic reset;
  int   passed;
  int   total;
  logic [9:0] obs;

  pipeline_controller_if bus ();

  pipeline_controller #(
    .MULTI_CYCLE_LATENCY (4),
    .COUNTER_WIDTH       (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .ctl   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stimulus word: {reset_n, start, cancel, flush, id_stall_request}
  localparam logic [4:0] I_NONE   = 5'b10000;
  localparam logic [4:0] I_START  = 5'b11000;
  localparam logic [4:0] I_CANCEL = 5'b10100;
  localparam logic [4:0] I_FLUSH  = 5'b10010;
  localparam logic [4:0] I_IDREQ  = 5'b10001;

  // Observation word: {stall[5:0], flush_out, id_ex_bubble, busy, done}
  localparam logic [9:0] E_ZERO       = 10'b000000_0000;
  localparam logic [9:0] E_EXS        = 10'b001111_0000;
  localparam logic [9:0] E_BUSY       = 10'b001111_0010;
  localparam logic [9:0] E_DONE       = 10'b000000_0001;
  localparam logic [9:0] E_FLUSH      = 10'b000000_1000;
  localparam logic [9:0] E_FLUSH_BUSY = 10'b000000_1010;
  localparam logic [9:0] E_LU         = 10'b000111_0100;
  localparam logic [9:0] E_LU_DONE    = 10'b000111_0101;

  task automatic apply(input logic [4:0] s);
    {reset, bus.ex_multi_cycle_start, bus.ex_multi_cycle_cancel,
     bus.flush, bus.id_stall_request} = s;
  endtask

  task automatic sample();
    obs = {bus.stall, bus.flush_out, bus.id_ex_bubble,
           bus.ex_multi_cycle_busy, bus.ex_multi_cycle_done};
  endtask

  task automatic test_reset();
    logic [4:0] stim [4] = '{5'b01010, 5'b01010, I_NONE, I_NONE};
    logic [9:0] exp  [4] = '{E_FLUSH, E_FLUSH, E_ZERO, E_ZERO};
    apply(5'b01010);
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      apply(stim[i]);
      @(negedge clock); sample();
      total++;
      if (obs !== exp[i]) $display("FAIL reset[%0d]: got %b want %b", i, obs, exp[i]);
      else passed++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_divide();
    logic [4:0] stim [7] = '{I_START, I_NONE, I_NONE, I_NONE, I_NONE, I_NONE, I_NONE};
    logic [9:0] exp  [7] = '{E_EXS, E_BUSY, E_BUSY, E_BUSY, E_BUSY, E_DONE, E_ZERO};
    for (int i = 0; i < 7; i++) begin
      apply(stim[i]);
      @(negedge clock); sample();
      total++;
      if (obs !== exp[i]) $display("FAIL divide[%0d]: got %b want %b", i, obs, exp[i]);
      else passed++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] stim [13] = '{I_START, I_START, I_START, I_START, I_START, I_START, I_START,
                              I_START, I_NONE, I_NONE, I_NONE, I_NONE, I_NONE};
    logic [9:0] exp  [13] = '{E_EXS, E_BUSY, E_BUSY, E_BUSY, E_BUSY, E_DONE, E_EXS,
                              E_BUSY, E_BUSY, E_BUSY, E_BUSY, E_DONE, E_ZERO};
    for (int i = 0; i < 13; i++) begin
      apply(stim[i]);
      @(negedge clock); sample();
      total++;
      if (obs !== exp[i]) $display("FAIL back_to_back[%0d]: got %b want %b", i, obs, exp[i]);
      else passed++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_load_use();
    logic [4:0] stim [3] = '{I_IDREQ, I_IDREQ, I_NONE};
    logic [9:0] exp  [3] = '{E_LU, E_LU, E_ZERO};
    for (int i = 0; i < 3; i++) begin
      apply(stim[i]);
      @(negedge clock); sample();
      total++;
      if (obs !== exp[i]) $display("FAIL load_use[%0d]: got %b want %b", i, obs, exp[i]);
      else passed++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_overlap();
    logic [4:0] stim [7] = '{I_START | I_IDREQ, I_IDREQ, I_IDREQ, I_IDREQ, I_IDREQ, I_IDREQ, I_NONE};
    logic [9:0] exp  [7] = '{E_EXS, E_BUSY, E_BUSY, E_BUSY, E_BUSY, E_LU_DONE, E_ZERO};
    for (int i = 0; i < 7; i++) begin
      apply(stim[i]);
      @(negedge clock); sample();
      total++;
      if (obs !== exp[i]) $display("FAIL overlap[%0d]: got %b want %b", i, obs, exp[i]);
      else passed++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_flush();
    logic [4:0] stim [12] = '{I_START, I_NONE, I_FLUSH, I_NONE, I_NONE, I_NONE, I_NONE, I_NONE,
                              I_START | I_FLUSH, I_NONE, I_FLUSH | I_IDREQ, I_NONE};
    logic [9:0] exp  [12] = '{E_EXS, E_BUSY, E_FLUSH_BUSY, E_ZERO, E_ZERO, E_ZERO, E_ZERO, E_ZERO,
                              E_FLUSH, E_ZERO, E_FLUSH, E_ZERO};
    for (int i = 0; i < 12; i++) begin
      apply(stim[i]);
      @(negedge clock); sample();
      total++;
      if (obs !== exp[i]) $display("FAIL flush[%0d]: got %b want %b", i, obs, exp[i]);
      else passed++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_cancel();
    logic [4:0] stim [14] = '{I_START, I_NONE, I_NONE, I_NONE, I_CANCEL, I_START | I_CANCEL,
                              I_NONE, I_NONE, I_NONE, I_NONE, I_CANCEL, I_NONE, I_CANCEL, I_NONE};
    logic [9:0] exp  [14] = '{E_EXS, E_BUSY, E_BUSY, E_BUSY, E_BUSY, E_EXS,
                              E_BUSY, E_BUSY, E_BUSY, E_BUSY, E_DONE, E_ZERO, E_ZERO, E_ZERO};
    for (int i = 0; i < 14; i++) begin
      apply(stim[i]);
      @(negedge clock); sample();
      total++;
      if (obs !== exp[i]) $display("FAIL cancel[%0d]: got %b want %b", i, obs, exp[i]);
      else passed++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [4:0] stim [10] = '{I_START, I_NONE, I_NONE, 5'b01000, I_NONE,
                              I_NONE, I_NONE, I_NONE, I_NONE, I_NONE};
    logic [9:0] exp  [10] = '{E_EXS, E_BUSY, E_BUSY, E_BUSY, E_ZERO,
                              E_ZERO, E_ZERO, E_ZERO, E_ZERO, E_ZERO};
    for (int i = 0; i < 10; i++) begin
      apply(stim[i]);
      @(negedge clock); sample();
      total++;
      if (obs !== exp[i]) $display("FAIL reset_mid_busy[%0d]: got %b want %b", i, obs, exp[i]);
      else passed++;
      @(posedge clock); #1;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    apply(5'b00000);
    test_reset();
    test_divide();
    test_back_to_back();
    test_load_use();
    test_overlap();
    test_flush();
    test_cancel();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
